// File: rtl/pulse_collector_pkg.sv
// pulse_collector_pkg: shared constants, channel-width helper and output-register states.
package pulse_collector_pkg;
   localparam int PC_MAX_CH = 32;
   localparam int PC_DEFAULT_CNT_W = 4;
   function automatic int pc_ch_w(int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
   typedef enum logic {PC_EMPTY, PC_FULL} pc_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from last_grant+1, last_grant moves only on advance.
module rr_arbiter
   import pulse_collector_pkg::*;
#(
   parameter int N = 4,
   localparam int W = pc_ch_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic         grant_vld,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);
   logic [W-1:0] last_grant;
   logic [W-1:0] idx;
   always_ff @(posedge clk)
      if (rst) last_grant <= W'(N - 1);
      else if (advance && grant_vld) last_grant <= grant_idx;
   // descending scan so the nearest requester after last_grant wins
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(last_grant) + k) % N);
         if (req[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end
   assign grant = grant_vld ? (N'(1) << grant_idx) : '0;
endmodule

// File: rtl/pulse_collector.sv
// pulse_collector: saturating per-channel pulse counters drained round-robin into a registered valid/ready stream.
// Overflow flags are built only when PULSE_COLLECTOR_OVF_EN is defined; otherwise out_ovf is 0.
module pulse_collector
   import pulse_collector_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W = PC_DEFAULT_CNT_W,
   localparam int CH_W = pc_ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] pulse_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0] cnt [NUM_CH];
   logic [NUM_CH-1:0] req, grant;
   logic [CH_W-1:0] grant_idx;
   logic grant_vld, load, advance;
   pc_state_e state, state_nxt;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_req
      assign req[i] = cnt[i] != '0;
   end
   rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk(clk),
      .rst(rst),
      .req(req),
      .advance(advance),
      .grant_vld(grant_vld),
      .grant(grant),
      .grant_idx(grant_idx)
   );
   always_ff @(posedge clk)
      if (rst) state <= PC_EMPTY;
      else state <= state_nxt;
   // accept and reload share a cycle, giving one payload per clock
   always_comb begin
      load = (state == PC_EMPTY) || out_ready;
      advance = load && grant_vld;
      state_nxt = load ? (grant_vld ? PC_FULL : PC_EMPTY) : state;
   end
   assign out_valid = state == PC_FULL;
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_CH; i++)
         if (rst) cnt[i] <= '0;
         else if (advance && grant[i]) cnt[i] <= CNT_W'(pulse_in[i]);
         else if (pulse_in[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
   always_ff @(posedge clk)
      if (rst) begin
         out_ch <= '0;
         out_count <= '0;
      end else if (advance) begin
         out_ch <= grant_idx;
         out_count <= cnt[grant_idx];
      end
`ifdef PULSE_COLLECTOR_OVF_EN
   logic [NUM_CH-1:0] ovf;
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_CH; i++)
         if (rst) ovf[i] <= 1'b0;
         else if (advance && grant[i]) ovf[i] <= 1'b0;
         else if (pulse_in[i] && cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
   always_ff @(posedge clk)
      if (rst) out_ovf <= 1'b0;
      else if (advance) out_ovf <= ovf[grant_idx];
`else
   assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_collector.sv
// tb_pulse_collector: table vectors plus corner sequences, payloads checked against an expected queue.
module tb_pulse_collector;
   typedef struct {
      logic [1:0] ch;
      logic [3:0] cnt;
      logic       ovf;
   } exp_t;
   typedef struct {
      logic [3:0] pulse;
      int         n;
      logic [7:0] chs;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] pulse_in = 4'b1111;
   logic out_ready = 1'b0;
   logic out_valid;
   logic [1:0] out_ch;
   logic [3:0] out_count;
   logic out_ovf;
   int checks = 0;
   int errors = 0;
   exp_t q[$];
   vec_t tbl[5];
`ifdef PULSE_COLLECTOR_OVF_EN
   localparam logic SAT_OVF = 1'b1;
`else
   localparam logic SAT_OVF = 1'b0;
`endif
   pulse_collector dut (
      .clk(clk),
      .rst(rst),
      .pulse_in(pulse_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ch(out_ch),
      .out_count(out_count),
      .out_ovf(out_ovf)
   );
   always #5 clk = ~clk;
   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_payload got ch=%0d count=%0d ovf=%0d, none expected", out_ch, out_count, out_ovf);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (out_ch !== e.ch || out_count !== e.cnt || out_ovf !== e.ovf) begin
               errors++;
               $display("FAIL payload got ch=%0d count=%0d ovf=%0d, expected ch=%0d count=%0d ovf=%0d",
                        out_ch, out_count, out_ovf, e.ch, e.cnt, e.ovf);
            end
         end
      end
   task automatic cyc(input logic [3:0] p, input logic r);
      @(posedge clk);
      #1;
      pulse_in = p;
      out_ready = r;
   endtask
   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask
   task automatic push(input logic [1:0] ch, input logic [3:0] c, input logic o);
      exp_t e;
      e.ch = ch;
      e.cnt = c;
      e.ovf = o;
      q.push_back(e);
   endtask
   // pulses held high during the reset cycle must be discarded
   task automatic do_rst();
      @(posedge clk);
      #1;
      rst = 1'b1;
      pulse_in = 4'b1111;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulse_in = 4'b0000;
      q.delete();
   endtask
   task automatic drain(input string name);
      int k;
      k = 0;
      while ((q.size() != 0 || out_valid) && k < 60) begin
         cyc(4'b0000, 1'b1);
         k++;
      end
      check(name, 8'(q.size()), 8'd0);
   endtask
   initial begin
      tbl[0] = '{4'b0001, 1, 8'h00};
      tbl[1] = '{4'b1111, 4, 8'hE4};
      tbl[2] = '{4'b1010, 2, 8'h0D};
      tbl[3] = '{4'b1100, 2, 8'h0E};
      tbl[4] = '{4'b0100, 1, 8'h02};
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      pulse_in = 4'b0000;
      check("reset_valid", 8'(out_valid), 8'd0);
      check("reset_ch", 8'(out_ch), 8'd0);
      check("reset_count", 8'(out_count), 8'd0);
      check("reset_ovf", 8'(out_ovf), 8'd0);
      for (int v = 0; v < 5; v++) begin
         do_rst();
         for (int j = 0; j < tbl[v].n; j++) push(tbl[v].chs[2*j +: 2], 4'd1, 1'b0);
         cyc(tbl[v].pulse, 1'b1);
         for (int k = 0; k <= tbl[v].n + 2; k++) begin
            check($sformatf("vec%0d_valid_c%0d", v, k), 8'(out_valid), 8'((k >= 2 && k < 2 + tbl[v].n) ? 1 : 0));
            cyc(4'b0000, 1'b1);
         end
         drain($sformatf("vec%0d_drained", v));
      end
      // batching: ch0 parks in the output register while ch2 accumulates
      do_rst();
      cyc(4'b0001, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      for (int j = 0; j < 5; j++) begin
         cyc(4'b0100, 1'b0);
         cyc(4'b0000, 1'b0);
      end
      check("batch_stall_ch", 8'(out_ch), 8'd0);
      push(2'd0, 4'd1, 1'b0);
      push(2'd2, 4'd5, 1'b0);
      drain("batch_drained");
      // saturation on ch1
      do_rst();
      cyc(4'b0001, 1'b0);
      cyc(4'b0000, 1'b0);
      repeat (20) cyc(4'b0010, 1'b0);
      cyc(4'b0000, 1'b0);
      check("sat_stall_valid", 8'(out_valid), 8'd1);
      push(2'd0, 4'd1, 1'b0);
      push(2'd1, 4'd15, SAT_OVF);
      drain("sat_drained");
      push(2'd1, 4'd1, 1'b0);
      cyc(4'b0010, 1'b1);
      drain("sat_next_drained");
      // ch3 pulses again in the cycle its first payload is loaded
      do_rst();
      push(2'd3, 4'd1, 1'b0);
      push(2'd3, 4'd1, 1'b0);
      cyc(4'b1000, 1'b1);
      cyc(4'b1000, 1'b1);
      drain("collision_drained");
      // reset mid-operation
      do_rst();
      cyc(4'b1111, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      check("midrst_pre_valid", 8'(out_valid), 8'd1);
      do_rst();
      check("midrst_post_valid", 8'(out_valid), 8'd0);
      begin
         int seen;
         seen = 0;
         repeat (10) begin
            cyc(4'b0000, 1'b1);
            if (out_valid) seen++;
         end
         check("midrst_quiet", 8'(seen), 8'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout got no finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/pulse_collector.md
# pulse_collector

Multi-channel, single-clock pulse event collector. It gives the UART control path a lossless way to funnel many sources into one event stream: each of `NUM_CH` pulse inputs feeds a saturating per-channel counter. A round-robin arbiter drains one channel per handshake through a registered valid/ready output, reporting the channel index and the number of pulses accumulated since its last drain. Back-to-back pulses on the same channel are never lost; they accumulate and are reported as a batch. The block replaces the one-pulse-in-flight, error-on-overrun restriction with counting plus flow control.

## Interface
- `NUM_CH`, default 4: number of pulse channels, 1..32.
- `CNT_W`, default 4: per-channel counter width; max reported count is 2^CNT_W-1.
- `CH_W`, derived as max(1, $clog2(NUM_CH)): channel index width; not user-overridable.
- `clk`  in  1  sole clock; all logic rises on posedge.
- `rst`  in  1  reset, synchronous and active-high; one clock, no async reset.
- `pulse_in`  in  NUM_CH  per-channel event; every cycle high counts as one pulse.
- `out_valid`  out  1  output payload valid.
- `out_ready`  in  1  consumer accepts the payload when high together with `out_valid`.
- `out_ch`  out  CH_W  channel index of the payload.
- `out_count`  out  CNT_W  pulses accumulated for `out_ch`, in the range 1..2^CNT_W-1.
- `out_ovf`  out  1  the counter for `out_ch` saturated and pulses were dropped.

## Operation
- **Per-channel counter `cnt[i]` (CNT_W bits) and sticky `ovf[i]`:**
  - Each cycle with `pulse_in[i]` high: `cnt[i]` increments by 1.
  - If `cnt[i]` is already at max, it holds and `ovf[i]` is set.
- **Output register** holds `{valid, ch, count, ovf}` and has two states:
  - EMPTY: `valid` = 0.
  - FULL: `valid` = 1.
- **Load condition:** the register may load when EMPTY, or when FULL and `out_valid && out_ready` (accept and reload in the same cycle, so full throughput is one payload per clock).
- **Arbiter request:** `req[i] = (cnt[i] != 0)`.
  - Priority is round-robin, searching upward from `last_grant+1` and wrapping from NUM_CH-1 to 0.
  - `last_grant` resets to NUM_CH-1, so channel 0 has priority first.
- **On load of channel g:**
  - `ch`, `count` and `ovf` take `g`, `cnt[g]` and `ovf[g]`.
  - `last_grant` becomes `g`.
  - `cnt[g]` becomes `pulse_in[g]` (0 or 1), so a pulse arriving in the drain cycle is kept.
  - `ovf[g]` clears.
- **Load with no request:**
  - If the register is FULL and accepted, it goes to EMPTY.
  - If it is EMPTY, it stays EMPTY.
- **Handshake rules:**
  - Once `out_valid` is high, it and the payload stay stable until accepted.
  - `out_ready` may toggle freely.
  - `out_ready` high while `out_valid` is low has no effect.
- **Width rules:**
  - `out_count` is never 0 while `out_valid` is high.
  - `out_ch` is always less than NUM_CH.
  - Counting saturates and never wraps.
- **Simultaneous events:** all channels may pulse in the same cycle. All counters update independently; only the granted channel is drained.
- **Reset:** `rst` high at a clock edge clears all state, wherever the block is in operation.
  - All counters are 0, all `ovf[i]` are 0, the output register is EMPTY, and `last_grant` is NUM_CH-1.
  - Pulses sampled in a reset cycle are discarded.

## Timing
- Reset values: `out_valid` = 0, `out_ch` = 0, `out_count` = 0, `out_ovf` = 0.
- All outputs are registered; there is no combinational path from `pulse_in` or `out_ready` to any output.
- **Idle latency:** `pulse_in[i]` high in cycle t gives `cnt[i]` = 1 from t+1 and `out_valid` = 1 in t+2.
- **Throughput:** one payload per cycle while requests are pending and `out_ready` is held high.
- **Fairness:** with all channels continuously requesting, a channel waits at most NUM_CH-1 grants.

## Configuration
- `PULSE_COLLECTOR_OVF_EN` defined:
  - `ovf[i]` flags are implemented and reported on `out_ovf` as described above.
- `PULSE_COLLECTOR_OVF_EN` undefined:
  - No `ovf` storage exists.
  - `out_ovf` is tied to 0.
  - Counters still saturate and the excess pulses are silently dropped.

## Structure
- **Package `pulse_collector_pkg`:**
  - Constants `PC_MAX_CH = 32` and `PC_DEFAULT_CNT_W = 4`.
  - Function `pc_ch_w(int n)` returning max(1, $clog2(n)).
  - The `pc_state_e` enum {PC_EMPTY, PC_FULL}.
- **Sub-module `rr_arbiter`:**
  - Parameter `N`.
  - Inputs: `clk`, `rst`, `req[N]`, `advance`.
  - Outputs: `grant_vld`, one-hot `grant[N]`, `grant_idx`.
  - Owns `last_grant` and updates it only when `advance` is high.
- **Top module** holds the counters, the overflow flags and the output register.

## Test plan
- **Idle single pulse:** reset, then `pulse_in` = 4'b0001 for 1 cycle with `out_ready` = 1 → `out_valid` high 2 cycles later with `out_ch` = 0, `out_count` = 1, `out_ovf` = 0; `out_valid` low the next cycle.
- **Batching:** with `out_ready` = 0, pulse ch2 on 5 separate cycles, then raise `out_ready` → exactly one payload with `out_ch` = 2, `out_count` = 5.
- **Round-robin:** `pulse_in` = 4'b1111 for 1 cycle with `out_ready` = 1 → payloads for ch 0, 1, 2, 3 on consecutive cycles, each with `out_count` = 1.
- **Saturation (CNT_W = 4):** with `out_ready` = 0, hold ch1 for 20 cycles → `out_count` = 15, and `out_ovf` = 1 with the macro defined (0 without it); ch1's next payload has `out_ovf` = 0.
- **Drain collision:** ch3 pulses in the exact cycle its payload is loaded → a second payload follows with `out_ch` = 3, `out_count` = 1; no pulse is lost.
- **Reset mid-operation:** with `out_valid` = 1 and counters nonzero, assert `rst` for 1 cycle → next cycle `out_valid` = 0 and no payloads appear afterwards without new pulses.
